risc_ctrl_fsm: RTL and testbench

//  Multi-cycle control sequencer for the 16-bit RISC datapath.
//  - Owns the PC and the instruction register (IR).
//  - Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the ALU select, GPR ports, dmem strobes and writeback MUX_3 select.
//  - Sits between imem and the datapath (GPR, ALU, dmem, MUX_3).

---
 rtl/risc16_pkg.sv | 63 ++++++
 rtl/risc_decode.sv | 75 +++++++
 rtl/risc_ctrl_fsm.sv | 187 ++++++++++++++++++
 tb/tb_risc_ctrl_fsm.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc16_pkg.sv
// risc16_pkg: shared constants and types for the 16-bit RISC control sequencer.
// Opcodes, ALU select codes, writeback mux codes, IR field positions,
// the sequencer state enum and the decoded-instruction struct.
package risc16_pkg;

    // Opcodes (IR[15:12])
    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_BEQ  = 4'h3;
    localparam logic [3:0] OP_JAL  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU select codes driven by the sequencer itself
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    // Writeback mux (MUX_3) select codes
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_DMEM = 2'b01;
    localparam logic [1:0] WB_PC2  = 2'b10;

    // IR field positions (low bit of each field)
    localparam int OPC_LSB  = 12;
    localparam int RS1_LSB  = 9;   // rs1 for R/LD/ST/BEQ, rd for JAL
    localparam int RS2_LSB  = 6;   // rs2 for R/ST/BEQ, rd for LD
    localparam int RD_R_LSB = 3;   // rd for R
    localparam int FN_LSB   = 0;   // alu_sel for R
    localparam int IMM_W    = 6;
    localparam int TGT_W    = 9;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    // Everything the sequencer needs to know about the instruction in IR
    typedef struct packed {
        logic        is_st;
        logic        is_beq;
        logic        is_jal;
        logic        is_halt;
        logic        writes_gpr;
        logic        uses_mem;
        logic [2:0]  alu_sel;
        logic        alu_b_imm;
        logic [1:0]  wb_sel;
        logic [2:0]  raddr1;
        logic [2:0]  raddr2;
        logic [2:0]  wdest;
        logic [15:0] imm;
        logic [15:0] jal_pc;
    } dec_t;

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

endpackage

// File: rtl/risc_decode.sv
// risc_decode: purely combinational IR decoder.
// Slices register fields, sign-extends imm6 and derives per-opcode control
// flags. Unknown opcodes decode as a NOP (all flags clear).
module risc_decode
    import risc16_pkg::*;
(
    input  logic [15:0] ir,
    output dec_t        dec
);

    logic [3:0] opc;
    logic [2:0] f_hi;
    logic [2:0] f_mid;
    logic [2:0] f_rd_r;
    logic [2:0] f_fn;

    assign opc    = ir[OPC_LSB +: 4];
    assign f_hi   = ir[RS1_LSB +: 3];
    assign f_mid  = ir[RS2_LSB +: 3];
    assign f_rd_r = ir[RD_R_LSB +: 3];
    assign f_fn   = ir[FN_LSB +: 3];

    // Field and flag decode; register ports stay 0 for opcodes that do not use them
    always_comb begin
        dec        = '0;
        dec.imm    = sext6(ir[IMM_W-1:0]);
        dec.jal_pc = {6'b0, ir[TGT_W-1:0], 1'b0};
        case (opc)
            OP_R: begin
                dec.writes_gpr = 1'b1;
                dec.alu_sel    = f_fn;
                dec.wb_sel     = WB_ALU;
                dec.raddr1     = f_hi;
                dec.raddr2     = f_mid;
                dec.wdest      = f_rd_r;
            end
            OP_LD: begin
                dec.writes_gpr = 1'b1;
                dec.uses_mem   = 1'b1;
                dec.alu_sel    = ALU_ADD;
                dec.alu_b_imm  = 1'b1;
                dec.wb_sel     = WB_DMEM;
                dec.raddr1     = f_hi;
                dec.wdest      = f_mid;
            end
            OP_ST: begin
                dec.is_st      = 1'b1;
                dec.uses_mem   = 1'b1;
                dec.alu_sel    = ALU_ADD;
                dec.alu_b_imm  = 1'b1;
                dec.raddr1     = f_hi;
                dec.raddr2     = f_mid;
            end
            OP_BEQ: begin
                dec.is_beq     = 1'b1;
                dec.alu_sel    = ALU_SUB;
                dec.raddr1     = f_hi;
                dec.raddr2     = f_mid;
            end
            OP_JAL: begin
                dec.is_jal     = 1'b1;
                dec.writes_gpr = 1'b1;
                dec.wb_sel     = WB_PC2;
                dec.wdest      = f_hi;
            end
            OP_HALT: begin
                dec.is_halt    = 1'b1;
            end
            default: begin
                // NOP: nothing to drive, PC simply advances
            end
        endcase
    end

endmodule

// File: rtl/risc_ctrl_fsm.sv
// risc_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the
// 16-bit RISC datapath. Owns PC and IR and drives ALU, GPR, dmem and MUX_3
// controls. Optional macro RISC_CTRL_PERF_EN adds retire/cycle counters.
module risc_ctrl_fsm
    import risc16_pkg::*;
#(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_run,
    input  logic [15:0] i_instr,
    input  logic        i_alu_zero,
    output logic [15:0] o_pc,
    output logic [15:0] o_ir,
    output logic [2:0]  o_alu_sel,
    output logic        o_alu_b_imm,
    output logic [15:0] o_imm,
    output logic        o_gpr_en,
    output logic        o_gpr_wen,
    output logic [2:0]  o_gpr_raddr1,
    output logic [2:0]  o_gpr_raddr2,
    output logic [2:0]  o_gpr_wdest,
    output logic [1:0]  o_wb_sel,
    output logic        o_dmem_en,
    output logic        o_dmem_wen,
    output logic        o_halted
`ifdef RISC_CTRL_PERF_EN
   ,output logic [15:0] o_retire_cnt,
    output logic [15:0] o_cycle_cnt
`endif
);

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] ir_q;
    logic [2:0]  alu_sel_q;
    logic        b_imm_q;
    logic [1:0]  wb_sel_q;
    logic        gpr_wen_q;
    logic        dmem_en_q;
    logic        dmem_wen_q;
    logic        halted_q;

    dec_t        dec;
    logic [15:0] pc_seq;
    logic [15:0] pc_br;

    risc_decode u_dec (
        .ir  (ir_q),
        .dec (dec)
    );

    // Sequential next PC and taken-branch target (word offset, hence << 1)
    assign pc_seq = pc_q + PC_STEP;
    assign pc_br  = pc_seq + {dec.imm[14:0], 1'b0};

    // Sequencer: each transition also loads the controls for the state being entered.
    // ALU select / B-operand mux are held until the instruction retires so the
    // combinational ALU result stays valid through MEM and WB.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= PC_RESET;
            ir_q       <= '0;
            alu_sel_q  <= ALU_ADD;
            b_imm_q    <= 1'b0;
            wb_sel_q   <= WB_ALU;
            gpr_wen_q  <= 1'b0;
            dmem_en_q  <= 1'b0;
            dmem_wen_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            // single-cycle strobes default low
            gpr_wen_q  <= 1'b0;
            dmem_en_q  <= 1'b0;
            dmem_wen_q <= 1'b0;
            wb_sel_q   <= WB_ALU;
            case (state_q)
                ST_FETCH: begin
                    if (i_run) begin
                        ir_q    <= i_instr;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (dec.is_halt) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q   <= ST_EXEC;
                        alu_sel_q <= dec.alu_sel;
                        b_imm_q   <= dec.alu_b_imm;
                    end
                end
                ST_EXEC: begin
                    if (dec.uses_mem) begin
                        state_q    <= ST_MEM;
                        dmem_en_q  <= 1'b1;
                        dmem_wen_q <= dec.is_st;
                    end else if (dec.writes_gpr) begin
                        state_q   <= ST_WB;
                        gpr_wen_q <= 1'b1;
                        wb_sel_q  <= dec.wb_sel;
                    end else begin
                        // BEQ resolves here from the ALU zero flag; NOP just steps
                        state_q   <= ST_FETCH;
                        pc_q      <= (dec.is_beq && i_alu_zero) ? pc_br : pc_seq;
                        alu_sel_q <= ALU_ADD;
                        b_imm_q   <= 1'b0;
                    end
                end
                ST_MEM: begin
                    if (dec.is_st) begin
                        state_q   <= ST_FETCH;
                        pc_q      <= pc_seq;
                        alu_sel_q <= ALU_ADD;
                        b_imm_q   <= 1'b0;
                    end else begin
                        state_q   <= ST_WB;
                        gpr_wen_q <= 1'b1;
                        wb_sel_q  <= dec.wb_sel;
                    end
                end
                ST_WB: begin
                    // PC is still the instruction's own address during WB, so the
                    // datapath's PC+2 link value is correct for JAL
                    state_q   <= ST_FETCH;
                    pc_q      <= dec.is_jal ? dec.jal_pc : pc_seq;
                    alu_sel_q <= ALU_ADD;
                    b_imm_q   <= 1'b0;
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    assign o_pc         = pc_q;
    assign o_ir         = ir_q;
    assign o_alu_sel    = alu_sel_q;
    assign o_alu_b_imm  = b_imm_q;
    assign o_imm        = dec.imm;
    assign o_gpr_en     = (state_q != ST_HALT);
    assign o_gpr_raddr1 = dec.raddr1;
    assign o_gpr_raddr2 = dec.raddr2;
    assign o_gpr_wdest  = dec.wdest;
    assign o_wb_sel     = wb_sel_q;
    assign o_halted     = halted_q;
    // Gate strobes with reset so a reset landing in MEM/WB writes nothing on that edge
    assign o_gpr_wen    = gpr_wen_q  & i_rst_n;
    assign o_dmem_en    = dmem_en_q  & i_rst_n;
    assign o_dmem_wen   = dmem_wen_q & i_rst_n;

`ifdef RISC_CTRL_PERF_EN
    logic        retire;
    logic [15:0] retire_cnt_q;
    logic [15:0] cycle_cnt_q;

    // An instruction retires on the edge that returns the sequencer to FETCH
    assign retire = ((state_q == ST_EXEC) && !dec.uses_mem && !dec.writes_gpr) ||
                    ((state_q == ST_MEM)  && dec.is_st) ||
                     (state_q == ST_WB);

    // Free-running performance counters, frozen once halted
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            retire_cnt_q <= '0;
            cycle_cnt_q  <= '0;
        end else if (state_q != ST_HALT) begin
            cycle_cnt_q <= cycle_cnt_q + 16'd1;
            if (retire) begin
                retire_cnt_q <= retire_cnt_q + 16'd1;
            end
        end
    end

    assign o_retire_cnt = retire_cnt_q;
    assign o_cycle_cnt  = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// tb_risc_ctrl_fsm: directed scenarios plus a randomized instruction stream,
// checked against an instruction-level model (latency table, PC rules).
module tb_risc_ctrl_fsm;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_run;
    logic [15:0] i_instr;
    logic        i_alu_zero;
    logic [15:0] o_pc;
    logic [15:0] o_ir;
    logic [2:0]  o_alu_sel;
    logic        o_alu_b_imm;
    logic [15:0] o_imm;
    logic        o_gpr_en;
    logic        o_gpr_wen;
    logic [2:0]  o_gpr_raddr1;
    logic [2:0]  o_gpr_raddr2;
    logic [2:0]  o_gpr_wdest;
    logic [1:0]  o_wb_sel;
    logic        o_dmem_en;
    logic        o_dmem_wen;
    logic        o_halted;
`ifdef RISC_CTRL_PERF_EN
    logic [15:0] o_retire_cnt;
    logic [15:0] o_cycle_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // instruction-level model state
    logic [15:0] model_pc;
    logic [15:0] model_ir;

    // values captured by exec_instr for scenario-specific checks
    logic [2:0]  cap_alu_sel;
    logic [2:0]  cap_wdest;
    logic [1:0]  cap_wb_sel;
    logic [15:0] cap_link;
    int          cap_wen_cycle;
    int          cap_dwen_cycle;

    risc_ctrl_fsm dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_run        (i_run),
        .i_instr      (i_instr),
        .i_alu_zero   (i_alu_zero),
        .o_pc         (o_pc),
        .o_ir         (o_ir),
        .o_alu_sel    (o_alu_sel),
        .o_alu_b_imm  (o_alu_b_imm),
        .o_imm        (o_imm),
        .o_gpr_en     (o_gpr_en),
        .o_gpr_wen    (o_gpr_wen),
        .o_gpr_raddr1 (o_gpr_raddr1),
        .o_gpr_raddr2 (o_gpr_raddr2),
        .o_gpr_wdest  (o_gpr_wdest),
        .o_wb_sel     (o_wb_sel),
        .o_dmem_en    (o_dmem_en),
        .o_dmem_wen   (o_dmem_wen),
        .o_halted     (o_halted)
`ifdef RISC_CTRL_PERF_EN
       ,.o_retire_cnt (o_retire_cnt),
        .o_cycle_cnt  (o_cycle_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    // cycles from FETCH to retirement
    function automatic int lat_of(input logic [15:0] ins);
        case (ins[15:12])
            4'h0:    return 4;
            4'h1:    return 5;
            4'h2:    return 4;
            4'h3:    return 3;
            4'h4:    return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int off6(input logic [15:0] ins);
        int v;
        v = int'(ins[5:0]);
        if (ins[5]) v = v - 64;
        return v;
    endfunction

    function automatic logic [15:0] pc_after(input logic [15:0] pc, input logic [15:0] ins,
                                             input logic zero);
        case (ins[15:12])
            4'h3:    return zero ? 16'(int'(pc) + 2 + 2 * off6(ins)) : 16'(int'(pc) + 2);
            4'h4:    return 16'(2 * int'(ins[8:0]));
            default: return 16'(int'(pc) + 2);
        endcase
    endfunction

    task automatic do_reset();
        i_rst_n    = 1'b0;
        i_run      = 1'($urandom);
        i_instr    = 16'($urandom);
        i_alu_zero = 1'($urandom);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n  = 1'b1;
        i_run    = 1'b0;
        model_pc = 16'h0000;
        model_ir = 16'h0000;
    endtask

    // Runs one non-HALT instruction from a FETCH cycle and checks every cycle of it.
    task automatic exec_instr(input logic [15:0] ins, input logic zero);
        logic [3:0]  op;
        int          lat;
        logic        is_mem, is_st, wr, e_bimm;
        logic [2:0]  e_alu, e_r1, e_r2, e_wd;
        logic [1:0]  e_wb;
        logic [15:0] e_imm;
        op     = ins[15:12];
        lat    = lat_of(ins);
        is_mem = (op == 4'h1) || (op == 4'h2);
        is_st  = (op == 4'h2);
        wr     = (op == 4'h0) || (op == 4'h1) || (op == 4'h4);
        e_alu  = (op == 4'h0) ? ins[2:0] : (op == 4'h3) ? 3'd1 : 3'd0;
        e_bimm = is_mem;
        e_r1   = (op <= 4'h3) ? ins[11:9] : 3'd0;
        e_r2   = (op == 4'h0 || op == 4'h2 || op == 4'h3) ? ins[8:6] : 3'd0;
        e_wd   = (op == 4'h0) ? ins[5:3] : (op == 4'h1) ? ins[8:6] : ins[11:9];
        e_wb   = (op == 4'h1) ? 2'd1 : (op == 4'h4) ? 2'd2 : 2'd0;
        e_imm  = 16'(off6(ins));
        cap_wen_cycle  = 0;
        cap_dwen_cycle = 0;

        checks++;
        if (o_pc !== model_pc || o_gpr_wen !== 1'b0 || o_dmem_en !== 1'b0 ||
            o_dmem_wen !== 1'b0 || o_halted !== 1'b0 || o_gpr_en !== 1'b1) begin
            errors++;
            $display("FAIL fetch_state: pc=%h wen=%b den=%b dwen=%b halt=%b en=%b expected pc=%h strobes 0 en 1",
                     o_pc, o_gpr_wen, o_dmem_en, o_dmem_wen, o_halted, o_gpr_en, model_pc);
        end
        i_instr    = ins;
        i_run      = 1'b1;
        i_alu_zero = zero;

        for (int k = 2; k <= lat; k++) begin
            @(posedge i_clk);
            #1;
            // in-flight instructions must ignore i_run / i_instr
            i_run   = 1'($urandom);
            i_instr = 16'($urandom);
            checks++;
            if (o_pc !== model_pc) begin
                errors++;
                $display("FAIL pc_hold ins=%h cyc=%0d: got %h expected %h", ins, k, o_pc, model_pc);
            end
            checks++;
            if (o_gpr_wen !== (wr && k == lat) || o_wb_sel !== ((wr && k == lat) ? e_wb : 2'b00)) begin
                errors++;
                $display("FAIL gpr_wb ins=%h cyc=%0d: got wen=%b wb=%0d expected wen=%b wb=%0d",
                         ins, k, o_gpr_wen, o_wb_sel, (wr && k == lat), ((wr && k == lat) ? e_wb : 2'b00));
            end
            checks++;
            if (o_dmem_en !== (is_mem && k == 4) || o_dmem_wen !== (is_st && k == 4)) begin
                errors++;
                $display("FAIL dmem ins=%h cyc=%0d: got en=%b wen=%b expected en=%b wen=%b",
                         ins, k, o_dmem_en, o_dmem_wen, (is_mem && k == 4), (is_st && k == 4));
            end
            if (k == 2) begin
                checks++;
                if (o_ir !== ins || o_gpr_raddr1 !== e_r1 || o_gpr_raddr2 !== e_r2 || o_imm !== e_imm) begin
                    errors++;
                    $display("FAIL decode ins=%h: got ir=%h r1=%0d r2=%0d imm=%h expected r1=%0d r2=%0d imm=%h",
                             ins, o_ir, o_gpr_raddr1, o_gpr_raddr2, o_imm, e_r1, e_r2, e_imm);
                end
            end
            if (k == 3) begin
                cap_alu_sel = o_alu_sel;
                checks++;
                if (o_alu_sel !== e_alu || o_alu_b_imm !== e_bimm) begin
                    errors++;
                    $display("FAIL exec_alu ins=%h: got sel=%0d bimm=%b expected sel=%0d bimm=%b",
                             ins, o_alu_sel, o_alu_b_imm, e_alu, e_bimm);
                end
            end
            if (wr && k == lat) begin
                cap_wdest  = o_gpr_wdest;
                cap_wb_sel = o_wb_sel;
                cap_link   = o_pc + 16'd2;
                checks++;
                if (o_gpr_wdest !== e_wd) begin
                    errors++;
                    $display("FAIL wdest ins=%h: got %0d expected %0d", ins, o_gpr_wdest, e_wd);
                end
            end
            if (o_gpr_wen === 1'b1)  cap_wen_cycle  = k;
            if (o_dmem_wen === 1'b1) cap_dwen_cycle = k;
        end

        @(posedge i_clk);
        #1;
        i_run    = 1'b0;
        model_pc = pc_after(model_pc, ins, zero);
        model_ir = ins;
        checks++;
        if (o_pc !== model_pc || o_gpr_wen !== 1'b0 || o_dmem_en !== 1'b0 || o_dmem_wen !== 1'b0) begin
            errors++;
            $display("FAIL pc_next ins=%h z=%b: got pc=%h wen=%b den=%b expected pc=%h strobes 0",
                     ins, zero, o_pc, o_gpr_wen, o_dmem_en, model_pc);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            i_run   = 1'b0;
            i_instr = 16'($urandom);
            @(posedge i_clk);
            #1;
            checks++;
            if (o_pc !== model_pc || o_ir !== model_ir || o_gpr_wen !== 1'b0 ||
                o_dmem_en !== 1'b0 || o_gpr_en !== 1'b1) begin
                errors++;
                $display("FAIL idle: got pc=%h ir=%h wen=%b den=%b en=%b expected pc=%h ir=%h",
                         o_pc, o_ir, o_gpr_wen, o_dmem_en, o_gpr_en, model_pc, model_ir);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_pc !== 16'h0000 || o_ir !== 16'h0000 || o_imm !== 16'h0000) begin
            errors++;
            $display("FAIL reset_pc_ir: got pc=%h ir=%h imm=%h expected 0", o_pc, o_ir, o_imm);
        end
        checks++;
        if (o_alu_sel !== 3'd0 || o_alu_b_imm !== 1'b0 || o_wb_sel !== 2'd0 ||
            o_gpr_raddr1 !== 3'd0 || o_gpr_raddr2 !== 3'd0 || o_gpr_wdest !== 3'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got alu=%0d bimm=%b wb=%0d r1=%0d r2=%0d wd=%0d expected 0",
                     o_alu_sel, o_alu_b_imm, o_wb_sel, o_gpr_raddr1, o_gpr_raddr2, o_gpr_wdest);
        end
        checks++;
        if (o_gpr_wen !== 1'b0 || o_dmem_en !== 1'b0 || o_dmem_wen !== 1'b0 || o_halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got wen=%b den=%b dwen=%b halt=%b expected 0",
                     o_gpr_wen, o_dmem_en, o_dmem_wen, o_halted);
        end
    endtask

    task automatic test_r_add();
        exec_instr(16'h0298, 1'b0);            // ADD r3 = r1 + r2
        checks++;
        if (cap_alu_sel !== 3'd0 || cap_wen_cycle != 4 || cap_wdest !== 3'd3 ||
            cap_wb_sel !== 2'd0 || o_pc !== 16'h0002) begin
            errors++;
            $display("FAIL r_add: got alu=%0d wen_cyc=%0d wd=%0d wb=%0d pc=%h expected 0 4 3 0 0002",
                     cap_alu_sel, cap_wen_cycle, cap_wdest, cap_wb_sel, o_pc);
        end
    endtask

    task automatic test_st_ld();
        exec_instr(16'h2283, 1'b0);            // ST r2 -> [r1+3]
        checks++;
        if (cap_dwen_cycle != 4 || cap_wen_cycle != 0) begin
            errors++;
            $display("FAIL st: got dwen_cyc=%0d wen_cyc=%0d expected 4 0", cap_dwen_cycle, cap_wen_cycle);
        end
        exec_instr(16'h1303, 1'b0);            // LD r4 <- [r1+3]
        checks++;
        if (cap_wen_cycle != 5 || cap_wb_sel !== 2'd1 || cap_wdest !== 3'd4 || cap_dwen_cycle != 0) begin
            errors++;
            $display("FAIL ld: got wen_cyc=%0d wb=%0d wd=%0d dwen_cyc=%0d expected 5 1 4 0",
                     cap_wen_cycle, cap_wb_sel, cap_wdest, cap_dwen_cycle);
        end
    endtask

    task automatic test_beq();
        do_reset();
        exec_instr(16'h5000, 1'b0);
        exec_instr(16'h5000, 1'b0);
        exec_instr(16'h32BE, 1'b1);            // BEQ off=-2 at PC=4, taken
        checks++;
        if (o_pc !== 16'h0002) begin
            errors++;
            $display("FAIL beq_taken: got pc=%h expected 0002", o_pc);
        end
        exec_instr(16'h5000, 1'b0);
        exec_instr(16'h32BE, 1'b0);            // same at PC=4, not taken
        checks++;
        if (o_pc !== 16'h0006) begin
            errors++;
            $display("FAIL beq_not_taken: got pc=%h expected 0006", o_pc);
        end
    endtask

    task automatic test_jal_wrap();
        do_reset();
        exec_instr(16'h32BE, 1'b1);            // 0 + 2 - 4 -> FFFE
        checks++;
        if (o_pc !== 16'hFFFE) begin
            errors++;
            $display("FAIL beq_wrap: got pc=%h expected fffe", o_pc);
        end
        exec_instr(16'h4E09, 1'b0);            // JAL r7, tgt=9
        checks++;
        if (cap_link !== 16'h0000 || cap_wdest !== 3'd7 || cap_wb_sel !== 2'd2 || o_pc !== 16'h0012) begin
            errors++;
            $display("FAIL jal_wrap: got link=%h wd=%0d wb=%0d pc=%h expected 0000 7 2 0012",
                     cap_link, cap_wdest, cap_wb_sel, o_pc);
        end
    endtask

    task automatic test_reset_in_wb();
        i_instr = 16'h0298;
        i_run   = 1'b1;
        repeat (3) begin
            @(posedge i_clk);
            #1;
            i_run = 1'b0;
        end
        checks++;
        if (o_gpr_wen !== 1'b1) begin
            errors++;
            $display("FAIL wb_reach: got wen=%b expected 1", o_gpr_wen);
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_gpr_wen !== 1'b0 || o_dmem_wen !== 1'b0) begin
            errors++;
            $display("FAIL wb_reset_gate: got wen=%b dwen=%b expected 0 0", o_gpr_wen, o_dmem_wen);
        end
        @(posedge i_clk);
        #1;
        checks++;
        if (o_pc !== 16'h0000 || o_ir !== 16'h0000 || o_gpr_wen !== 1'b0 || o_wb_sel !== 2'd0) begin
            errors++;
            $display("FAIL wb_reset_state: got pc=%h ir=%h wen=%b wb=%0d expected 0",
                     o_pc, o_ir, o_gpr_wen, o_wb_sel);
        end
        i_rst_n  = 1'b1;
        model_pc = 16'h0000;
        model_ir = 16'h0000;
        exec_instr(16'h5000, 1'b0);            // proves the sequencer restarted in FETCH
    endtask

    task automatic test_random();
        logic [15:0] ins;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
            ins = {4'($urandom_range(0, 14)), 12'($urandom)};
            exec_instr(ins, 1'($urandom));
        end
    endtask

    task automatic test_halt();
        do_reset();
        idle_cycles(3);
        i_instr = 16'hF000;
        i_run   = 1'b1;
        @(posedge i_clk);
        #1;
        checks++;
        if (o_halted !== 1'b0 || o_ir !== 16'hF000) begin
            errors++;
            $display("FAIL halt_decode: got halt=%b ir=%h expected 0 f000", o_halted, o_ir);
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge i_clk);
            #1;
            i_run      = 1'($urandom);
            i_instr    = 16'($urandom);
            i_alu_zero = 1'($urandom);
            checks++;
            if (o_halted !== 1'b1 || o_gpr_en !== 1'b0 || o_gpr_wen !== 1'b0 || o_dmem_en !== 1'b0 ||
                o_dmem_wen !== 1'b0 || o_wb_sel !== 2'd0 || o_pc !== model_pc) begin
                errors++;
                $display("FAIL halted: got halt=%b en=%b wen=%b den=%b dwen=%b pc=%h expected 1 0 0 0 0 pc=%h",
                         o_halted, o_gpr_en, o_gpr_wen, o_dmem_en, o_dmem_wen, o_pc, model_pc);
            end
        end
        do_reset();
        checks++;
        if (o_halted !== 1'b0 || o_pc !== 16'h0000 || o_gpr_en !== 1'b1) begin
            errors++;
            $display("FAIL halt_exit: got halt=%b pc=%h en=%b expected 0 0000 1", o_halted, o_pc, o_gpr_en);
        end
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_run      = 1'b0;
        i_instr    = '0;
        i_alu_zero = 1'b0;
        model_pc   = '0;
        model_ir   = '0;
        test_reset();
        test_r_add();
        test_st_ld();
        test_beq();
        test_jal_wrap();
        test_reset_in_wb();
        test_random();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
